reg_file_32x32: RTL
===================

REG_FILE_32X32 -- requirements
Module: reg_file_32x32

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the data width in bits.
REQ-002 Parameter NREG, default 32, SHALL set the register count; the address width SHALL be AW = log2(NREG) = 5.
REQ-003 Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Reset_n  input  1  SHALL be the reset, synchronous and active-low.
REQ-005 Wr_En  input  1  SHALL be the write enable.
REQ-006 Wr_Addr  input  AW  SHALL be the write register index.
REQ-007 Wr_Data  input  XLEN  SHALL be the write data.
REQ-008 Rs1_Addr, Rs2_Addr  input  AW each  SHALL be the read-port indices.
REQ-009 Rs1_Data, Rs2_Data  output  XLEN each  SHALL be the read-port data.
REQ-010 Dump_Start  input  1  SHALL request a sequential readout of all registers.
REQ-011 Dump_Busy  output  1  SHALL indicate that a dump is in progress.
REQ-012 Dump_Valid  output  1  SHALL qualify Dump_Addr and Dump_Data.
REQ-013 Dump_Ready  input  1  SHALL be the consumer acceptance signal.
REQ-014 Dump_Addr  output  AW  SHALL be the index of the offered register.
REQ-015 Dump_Data  output  XLEN  SHALL be the offered register value.
REQ-016 Dump_Done  output  1  SHALL be a one-cycle pulse marking dump completion.

Function
REQ-017 A write SHALL occur at the rising edge when Wr_En=1 and Wr_Addr!=0.
REQ-018 Register x0 SHALL always read 0; writes to x0 SHALL be discarded.
REQ-019 Read ports SHALL be combinational: RsN_Data = reg[RsN_Addr] in the same cycle.
REQ-020 Bypass: when Wr_En=1, Wr_Addr=RsN_Addr and RsN_Addr!=0, RsN_Data SHALL equal Wr_Data in that cycle.
REQ-021 Both read ports SHALL be independent; identical addresses SHALL return identical data.
REQ-022 Dump FSM states SHALL be IDLE, SEND and DONE.
REQ-023 From IDLE with Dump_Start=1, the FSM SHALL move to SEND with index 0 and Dump_Busy=1 from the next cycle.
REQ-024 In SEND, Dump_Valid SHALL be 1 and Dump_Addr SHALL equal the index.
REQ-025 Dump_Data SHALL be a registered snapshot of reg[index], captured on the cycle the index became current (bypassed value if written that same edge), and SHALL hold stable while Dump_Valid=1 and Dump_Ready=0.
REQ-026 A transfer SHALL occur when Dump_Valid and Dump_Ready are both 1; the index SHALL then increment and a new snapshot SHALL be offered in the next cycle, with no bubble.
REQ-027 A transfer at index NREG-1 SHALL move the FSM to DONE; DONE SHALL assert Dump_Done for exactly one cycle, then return to IDLE.
REQ-028 Dump_Start SHALL be ignored in SEND and DONE.
REQ-029 Normal writes and reads SHALL proceed unaffected during a dump; a write to the register currently offered SHALL NOT alter the held Dump_Data.
REQ-030 One dump SHALL emit exactly NREG transfers, indices 0..NREG-1 in order; index 0 SHALL carry data 0.

Reset
REQ-031 When Reset_n=0 at a rising edge, all registers SHALL clear to 0 and the FSM SHALL enter IDLE with index 0.
REQ-032 After reset, Dump_Busy, Dump_Valid and Dump_Done SHALL be 0, and Dump_Addr and Dump_Data SHALL be 0.
REQ-033 Reset asserted mid-dump SHALL abort the dump with no Dump_Done pulse.
REQ-034 Reset SHALL take priority over a simultaneous Wr_En and over Dump_Start.

Structure
REQ-035 A package regfile_pkg SHALL hold XLEN, NREG and AW, plus the dump_state_t enum {IDLE, SEND, DONE}.
REQ-036 The dump sequencer (FSM, index counter and snapshot register) SHALL be the single sub-module regfile_dump_fsm; the storage array and read ports SHALL remain in the top module.

Verification
REQ-037 Scenario: write x5=0xDEADBEEF, next cycle Rs1_Addr=5 -> Rs1_Data=0xDEADBEEF; write x0=0x1234, Rs2_Addr=0 -> Rs2_Data=0.
REQ-038 Scenario: Wr_En=1, Wr_Addr=7, Wr_Data=0xA5A5A5A5, Rs1_Addr=Rs2_Addr=7 in the same cycle -> both read ports show 0xA5A5A5A5 that cycle.
REQ-039 Scenario: load xi=i*0x11 for i=1..31, pulse Dump_Start, hold Dump_Ready=1 -> 32 consecutive transfers (addr i, data i*0x11, x0=0), then a single Dump_Done pulse, then Dump_Busy=0.
REQ-040 Scenario: during a dump, hold Dump_Ready=0 for 3 cycles at index 4 while writing x4=0xFFFFFFFF -> Dump_Data stays at the old x4 value; x5 is offered after acceptance.
REQ-041 Scenario: Reset_n=0 for one cycle at index 10 of a dump -> next cycle Dump_Valid=0, Dump_Busy=0, no Dump_Done, and all registers read 0.
REQ-042 Scenario: random write and read traffic with a random Dump_Ready pattern, checked against a reference model -> data matches at every read and every transfer, and the dump yields exactly 32 transfers.

Source files
------------

// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared sizing constants and the dump sequencer state type for the
// 32x32 register file.
//   XLEN         : data width in bits
//   NREG         : number of architectural registers
//   AW           : register index width
//   dump_state_t : IDLE / SEND / DONE
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dump_state_t;

endpackage

// File: rtl/reg_file_32x32_if.sv
// ----------------------------------------------------------------------------
// reg_file_32x32_if
// Bus bundle for the register file: write port, two read ports and the
// valid/ready dump stream.
//   master : drives writes, read indices, Dump_Start and Dump_Ready
//   slave  : the register file itself
// ----------------------------------------------------------------------------
interface reg_file_32x32_if #(
    parameter int DATA_W  = regfile_pkg::XLEN,
    parameter int NUM_REG = regfile_pkg::NREG
);
    localparam int AW = $clog2(NUM_REG);

    logic              Wr_En;
    logic [AW-1:0]     Wr_Addr;
    logic [DATA_W-1:0] Wr_Data;
    logic [AW-1:0]     Rs1_Addr;
    logic [AW-1:0]     Rs2_Addr;
    logic [DATA_W-1:0] Rs1_Data;
    logic [DATA_W-1:0] Rs2_Data;
    logic              Dump_Start;
    logic              Dump_Busy;
    logic              Dump_Valid;
    logic              Dump_Ready;
    logic [AW-1:0]     Dump_Addr;
    logic [DATA_W-1:0] Dump_Data;
    logic              Dump_Done;

    modport master (
        output Wr_En, Wr_Addr, Wr_Data, Rs1_Addr, Rs2_Addr, Dump_Start, Dump_Ready,
        input  Rs1_Data, Rs2_Data, Dump_Busy, Dump_Valid, Dump_Addr, Dump_Data, Dump_Done
    );

    modport slave (
        input  Wr_En, Wr_Addr, Wr_Data, Rs1_Addr, Rs2_Addr, Dump_Start, Dump_Ready,
        output Rs1_Data, Rs2_Data, Dump_Busy, Dump_Valid, Dump_Addr, Dump_Data, Dump_Done
    );

endinterface

// File: rtl/regfile_dump_fsm.sv
// ----------------------------------------------------------------------------
// regfile_dump_fsm
// Sequential readout of every register over a valid/ready stream.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no dump; waits for Dump_Start
//   SEND  | offering reg[index] on Dump_Addr/Dump_Data with Dump_Valid=1
//   DONE  | one-cycle Dump_Done pulse, then back to IDLE
//
// Ports:
//   Clk, Reset_n            : clock, synchronous active-low reset
//   Dump_Start, Dump_Ready  : dump request, consumer acceptance
//   snap_addr / snap_data   : index of the next register and its current
//                             (write-bypassed) value, supplied by the top
//   Dump_Busy/Valid/Done    : status and stream qualifier
//   Dump_Addr/Dump_Data     : offered index and snapshot
// ----------------------------------------------------------------------------
module regfile_dump_fsm import regfile_pkg::*; #(
    parameter int DATA_W  = XLEN,
    parameter int NUM_REG = NREG
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       Dump_Start,
    input  logic                       Dump_Ready,
    output logic [$clog2(NUM_REG)-1:0] snap_addr,
    input  logic [DATA_W-1:0]          snap_data,
    output logic                       Dump_Busy,
    output logic                       Dump_Valid,
    output logic                       Dump_Done,
    output logic [$clog2(NUM_REG)-1:0] Dump_Addr,
    output logic [DATA_W-1:0]          Dump_Data
);
    localparam int IDX_W = $clog2(NUM_REG);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REG - 1);

    dump_state_t       state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] data_q;
    logic              xfer;
    logic              last;

    assign xfer      = (state_q == SEND) && Dump_Ready;
    assign last      = (idx_q == LAST_IDX);
    assign snap_addr = idx_q + 1'b1;
    assign Dump_Addr = idx_q;
    assign Dump_Data = data_q;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        Dump_Busy  = 1'b0;
        Dump_Valid = 1'b0;
        Dump_Done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Dump_Start) state_d = SEND;
            end
            SEND: begin
                Dump_Busy  = 1'b1;
                Dump_Valid = 1'b1;
                if (xfer && last) state_d = DONE;
            end
            DONE: begin
                Dump_Busy = 1'b1;
                Dump_Done = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Snapshot is taken on the edge where the index advances, so a later
    // write to the offered register cannot disturb a stalled transfer.
    // Index 0 is x0, which is always zero.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            idx_q  <= '0;
            data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Dump_Start) begin
                        idx_q  <= '0;
                        data_q <= '0;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (last) begin
                            idx_q  <= '0;
                            data_q <= '0;
                        end else begin
                            idx_q  <= snap_addr;
                            data_q <= snap_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/reg_file_32x32.sv
// ----------------------------------------------------------------------------
// reg_file_32x32
// NREG x XLEN register file, x0 hardwired to zero, two combinational read
// ports with write bypass, plus a sequential dump of all registers.
// Ports:
//   Clk     : clock, all state on rising edge
//   Reset_n : synchronous active-low reset (clears registers, aborts dump)
//   bus     : reg_file_32x32_if.slave (write port, read ports, dump stream)
// ----------------------------------------------------------------------------
module reg_file_32x32 #(
    parameter int XLEN = regfile_pkg::XLEN,
    parameter int NREG = regfile_pkg::NREG
) (
    input logic            Clk,
    input logic            Reset_n,
    reg_file_32x32_if.slave bus
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs [NREG];
    logic [AW-1:0]   snap_addr;
    logic [XLEN-1:0] snap_data;
    logic            wr_fire;

    assign wr_fire = bus.Wr_En && (bus.Wr_Addr != '0);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_fire) begin
            regs[bus.Wr_Addr] <= bus.Wr_Data;
        end
    end

    // Reads see a same-cycle write to the same index; x0 always reads zero.
    assign bus.Rs1_Data = (bus.Rs1_Addr == '0) ? '0 :
                          (wr_fire && (bus.Wr_Addr == bus.Rs1_Addr)) ? bus.Wr_Data :
                          regs[bus.Rs1_Addr];

    assign bus.Rs2_Data = (bus.Rs2_Addr == '0) ? '0 :
                          (wr_fire && (bus.Wr_Addr == bus.Rs2_Addr)) ? bus.Wr_Data :
                          regs[bus.Rs2_Addr];

    // Third read port feeding the dump snapshot, same bypass rule.
    assign snap_data = (snap_addr == '0) ? '0 :
                       (wr_fire && (bus.Wr_Addr == snap_addr)) ? bus.Wr_Data :
                       regs[snap_addr];

    regfile_dump_fsm #(
        .DATA_W  (XLEN),
        .NUM_REG (NREG)
    ) u_dump (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Dump_Start (bus.Dump_Start),
        .Dump_Ready (bus.Dump_Ready),
        .snap_addr  (snap_addr),
        .snap_data  (snap_data),
        .Dump_Busy  (bus.Dump_Busy),
        .Dump_Valid (bus.Dump_Valid),
        .Dump_Done  (bus.Dump_Done),
        .Dump_Addr  (bus.Dump_Addr),
        .Dump_Data  (bus.Dump_Data)
    );

endmodule
